// File: rtl/cycenc_arb_ctrl.sv
// cycenc_arb_ctrl: two-requester round-robin front end sharing one (7,4) cyclic encoder LFSR, g(x)=1+x+x^3.
// Define CYCENC_STAT_EN to enable the frame_cnt completed-codeword counter; otherwise frame_cnt is tied to 0.
module cycenc_arb_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_msg0,
    input  logic [3:0] req_msg1,
    output logic [1:0] req_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_code,
    output logic       out_id,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
    state_t state, state_nxt;
    logic       ptr, gid, accept, fb, done, id;
    logic [3:0] msg;
    logic [2:0] s;
    logic [1:0] cnt;
    always_comb begin
        state_nxt = state;
        gid       = (req_valid == 2'b11) ? ptr : req_valid[1];
        req_ready = (state == IDLE && rst && |req_valid) ? (gid ? 2'b10 : 2'b01) : 2'b00;
        accept    = |(req_valid & req_ready);
        // ~cnt walks the message MSB first: cnt 0..3 selects bit 3..0
        fb        = msg[~cnt] ^ s[2];
        done      = (state == OUT) && out_ready;
        case (state)
            IDLE:    state_nxt = accept ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == 2'd3) ? OUT : SHIFT;
            OUT:     state_nxt = out_ready ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            msg   <= '0;
            id    <= 1'b0;
            s     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr <= ~gid;
                msg <= gid ? req_msg1 : req_msg0;
                id  <= gid;
                s   <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                s   <= {s[1], s[0] ^ fb, fb};
                cnt <= cnt + 2'd1;
            end
        end
    end
    assign out_valid = (state == OUT);
    assign out_code  = out_valid ? {msg, s} : 7'd0;
    assign out_id    = out_valid & id;
    assign busy      = (state != IDLE);
`ifdef CYCENC_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst) frame_cnt <= '0;
        else if (done) frame_cnt <= frame_cnt + 8'd1;
    end
`else
    assign frame_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_cycenc_arb_ctrl.sv
// tb_cycenc_arb_ctrl: directed self-checking bench for cycenc_arb_ctrl.
module tb_cycenc_arb_ctrl;
`ifdef CYCENC_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_msg0, req_msg1;
    logic [1:0] req_ready;
    logic       out_valid, out_ready, out_id, busy;
    logic [6:0] out_code;
    logic [7:0] frame_cnt;
    int tests = 0;
    int failed = 0;
    int exp_frames = 0;

    cycenc_arb_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg0(req_msg0), .req_msg1(req_msg1),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_id(out_id), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_fc();
        logic [31:0] f;
        f = exp_frames;
        return STAT ? f[7:0] : 8'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_frames = 0;
    endtask

    // Drives one request at a negedge, waits out the encode and completes the handshake; ends at a negedge in IDLE.
    task automatic run_frame(input logic [1:0] v, input logic [3:0] m0, input logic [3:0] m1, input bit hold,
                             output logic [1:0] rdy, output int lat, output logic [6:0] code, output logic oid);
        req_valid = v;
        req_msg0  = m0;
        req_msg1  = m1;
        out_ready = 1'b1;
        #1 rdy = req_ready;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 2'b00;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        code = out_code;
        oid  = out_id;
        @(posedge clk);
        @(negedge clk);
        if (lat < 20) exp_frames++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b11;
        req_msg0 = 4'h1;
        req_msg1 = 4'h8;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 2'b00) begin failed++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_code !== 7'd0) begin failed++; $display("FAIL reset_out_code got %b exp 0000000", out_code); end
        tests++; if (out_id !== 1'b0) begin failed++; $display("FAIL reset_out_id got %b exp 0", out_id); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (frame_cnt !== 8'd0) begin failed++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        req_valid = 2'b00;
        rst = 1'b1;
        exp_frames = 0;
    endtask

    task automatic test_req0_only();
        logic [1:0] rdy; int lat; logic [6:0] code; logic oid;
        run_frame(2'b01, 4'b0001, 4'b0000, 1'b0, rdy, lat, code, oid);
        tests++; if (rdy !== 2'b01) begin failed++; $display("FAIL req0_ready got %b exp 01", rdy); end
        tests++; if (lat !== 4) begin failed++; $display("FAIL req0_latency got %0d exp 4", lat); end
        tests++; if (code !== 7'b0001011) begin failed++; $display("FAIL req0_code got %b exp 0001011", code); end
        tests++; if (oid !== 1'b0) begin failed++; $display("FAIL req0_id got %b exp 0", oid); end
        tests++; if (frame_cnt !== exp_fc()) begin failed++; $display("FAIL req0_frame_cnt got %0d exp %0d", frame_cnt, exp_fc()); end
    endtask

    task automatic test_req1_seq();
        logic [3:0] msgs [3] = '{4'b1000, 4'b1111, 4'b0000};
        logic [6:0] exps [3] = '{7'b1000101, 7'b1111111, 7'b0000000};
        logic [1:0] rdy; int lat; logic [6:0] code; logic oid;
        for (int i = 0; i < 3; i++) begin
            run_frame(2'b10, 4'b0000, msgs[i], 1'b0, rdy, lat, code, oid);
            tests++; if (rdy !== 2'b10) begin failed++; $display("FAIL req1_ready[%0d] got %b exp 10", i, rdy); end
            tests++; if (lat !== 4) begin failed++; $display("FAIL req1_latency[%0d] got %0d exp 4", i, lat); end
            tests++; if (code !== exps[i]) begin failed++; $display("FAIL req1_code[%0d] got %b exp %b", i, code, exps[i]); end
            tests++; if (oid !== 1'b1) begin failed++; $display("FAIL req1_id[%0d] got %b exp 1", i, oid); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] rdy; int lat; logic [6:0] code; logic oid;
        logic       eid [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] ecd [4] = '{7'b0001011, 7'b1000101, 7'b0001011, 7'b1000101};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(2'b11, 4'b0001, 4'b1000, 1'b1, rdy, lat, code, oid);
            tests++; if (oid !== eid[i]) begin failed++; $display("FAIL rr_id[%0d] got %b exp %b", i, oid, eid[i]); end
            tests++; if (rdy !== (eid[i] ? 2'b10 : 2'b01)) begin failed++; $display("FAIL rr_ready[%0d] got %b exp %b", i, rdy, eid[i] ? 2'b10 : 2'b01); end
            tests++; if (code !== ecd[i]) begin failed++; $display("FAIL rr_code[%0d] got %b exp %b", i, code, ecd[i]); end
        end
        req_valid = 2'b00;
        tests++; if (frame_cnt !== exp_fc()) begin failed++; $display("FAIL rr_frame_cnt got %0d exp %0d", frame_cnt, exp_fc()); end
    endtask

    task automatic test_backpressure();
        int w;
        req_valid = 2'b01;
        req_msg0  = 4'b1111;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        tests++; if (w !== 4) begin failed++; $display("FAIL bp_latency got %0d exp 4", w); end
        for (int i = 0; i < 10; i++) begin
            tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
            tests++; if (out_code !== 7'b1111111) begin failed++; $display("FAIL bp_code[%0d] got %b exp 1111111", i, out_code); end
            tests++; if (out_id !== 1'b0) begin failed++; $display("FAIL bp_id[%0d] got %b exp 0", i, out_id); end
            tests++; if (req_ready !== 2'b00) begin failed++; $display("FAIL bp_ready[%0d] got %b exp 00", i, req_ready); end
            tests++; if (busy !== 1'b1) begin failed++; $display("FAIL bp_busy[%0d] got %b exp 1", i, busy); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_frames++;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL bp_release_busy got %b exp 0", busy); end
        tests++; if (req_ready !== 2'b10) begin failed++; $display("FAIL bp_release_ready got %b exp 10", req_ready); end
        tests++; if (frame_cnt !== exp_fc()) begin failed++; $display("FAIL bp_frame_cnt got %0d exp %0d", frame_cnt, exp_fc()); end
        req_valid = 2'b00;
    endtask

    task automatic test_mid_reset();
        logic [1:0] rdy; int lat; logic [6:0] code; logic oid;
        req_valid = 2'b01;
        req_msg0  = 4'b0001;
        req_msg1  = 4'b1000;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_frames = 0;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        tests++; if (frame_cnt !== 8'd0) begin failed++; $display("FAIL mid_rst_frame_cnt got %0d exp 0", frame_cnt); end
        rst = 1'b1;
        run_frame(2'b11, 4'b0001, 4'b1000, 1'b0, rdy, lat, code, oid);
        tests++; if (rdy !== 2'b01) begin failed++; $display("FAIL mid_rst_grant got %b exp 01", rdy); end
        tests++; if (oid !== 1'b0) begin failed++; $display("FAIL mid_rst_id got %b exp 0", oid); end
        tests++; if (code !== 7'b0001011) begin failed++; $display("FAIL mid_rst_code got %b exp 0001011", code); end
    endtask

    task automatic test_frame_cnt();
        logic [1:0] rdy; int lat; logic [6:0] code; logic oid;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            run_frame(2'b01, 4'b0101, 4'b0000, 1'b0, rdy, lat, code, oid);
            tests++; if (frame_cnt !== exp_fc()) begin failed++; $display("FAIL fc_step[%0d] got %0d exp %0d", i, frame_cnt, exp_fc()); end
        end
        tests++; if (frame_cnt !== (STAT ? 8'd1 : 8'd0)) begin failed++; $display("FAIL fc_wrap got %0d exp %0d", frame_cnt, STAT ? 1 : 0); end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 2'b00;
        req_msg0 = 4'h0;
        req_msg1 = 4'h0;
        out_ready = 1'b0;
        test_reset();
        @(negedge clk);
        test_req0_only();
        test_req1_seq();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_frame_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/cycenc_arb_ctrl.md
CYCENC_ARB_CTRL -- requirements
Module: cycenc_arb_ctrl

Interface
REQ-001 Module SHALL have no parameters.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester message valid; bit i = requester i.
REQ-005 req_msg0, req_msg1  input  4 each  message data from requester 0 / 1.
REQ-006 req_ready  output  2  per-requester accept strobe; at most one bit high.
REQ-007 out_valid  output  1  codeword available.
REQ-008 out_ready  input  1  downstream accepts codeword.
REQ-009 out_code  output  7  systematic (7,4) cyclic codeword.
REQ-010 out_id  output  1  index of requester that supplied out_code.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 frame_cnt  output  8  completed-codeword count (see Configuration).

Function
REQ-013 Block SHALL share one internal division LFSR (g(x)=1+x+x^3) between two requesters.
REQ-014 FSM states SHALL be IDLE, SHIFT, OUT.
REQ-015 IDLE: req_ready[i] SHALL be combinationally high only for the granted requester i with req_valid[i]=1; accept = req_valid[i]&req_ready[i] at an edge.
REQ-016 Grant: single valid requester wins; both valid -> requester indicated by round-robin pointer wins.
REQ-017 Pointer SHALL update on accept to the requester not served; it SHALL be 0 after reset.
REQ-018 On accept: capture message and id, clear LFSR (s2,s1,s0)=0, clear 2-bit shift count, go to SHIFT.
REQ-019 SHIFT: one message bit per cycle, MSB first (msg[3],msg[2],msg[1],msg[0]); f=d^s2; s2<=s1; s1<=s0^f; s0<=f.
REQ-020 After the 4th SHIFT cycle, state SHALL go to OUT, with out_valid high starting 4 cycles after the accept edge.
REQ-021 out_code[6:3] SHALL equal captured msg[3:0]; out_code[2:0] SHALL equal {s2,s1,s0} (remainder of m(x)*x^3 mod g(x)).
REQ-022 OUT: out_valid, out_code, out_id SHALL hold stable until out_valid&out_ready at an edge, then return to IDLE.
REQ-023 req_ready SHALL be 0 in SHIFT and OUT; a new accept SHALL occur no earlier than the cycle after the OUT handshake edge.
REQ-024 Requesters SHALL hold req_msg stable while req_valid is high and req_ready is low; the block does not sample req_msg outside the accept edge.
REQ-025 req_valid deasserted while not granted SHALL have no effect on state or pointer.

Reset
REQ-026 rst=0 at an edge, in any state including mid-SHIFT or OUT, SHALL force IDLE, pointer 0, LFSR 0, and count 0; in-flight message is discarded.
REQ-027 Reset values SHALL be: out_valid 0, out_code 0, out_id 0, busy 0, frame_cnt 0; req_ready SHALL be 0 while rst=0.

Configuration
REQ-028 Macro CYCENC_STAT_EN defined: frame_cnt SHALL increment by 1 on each OUT handshake edge, wrapping 255->0.
REQ-029 Macro CYCENC_STAT_EN undefined: frame_cnt port SHALL remain present and be tied to 0; no counter logic.

Verification
REQ-030 Requester 0 only, msg=4'b0001 -> out_code=7'b0001011, out_id=0, out_valid 4 cycles after accept.
REQ-031 Requester 1 only, msg=4'b1000, then 4'b1111, then 4'b0000 -> out_code 7'b1000101, 7'b1111111, 7'b0000000, out_id=1 each.
REQ-032 Both valid continuously after reset (msg0=4'b0001, msg1=4'b1000), out_ready=1 -> grant order 0,1,0,1; out_id alternates accordingly.
REQ-033 out_ready held 0 for 10 cycles in OUT -> out_code/out_id stable, req_ready=00, busy=1; out_ready=1 -> IDLE on next edge.
REQ-034 rst=0 during 2nd SHIFT cycle -> next cycle out_valid=0, busy=0, frame_cnt=0; next accept goes to requester 0 when both valid.
REQ-035 CYCENC_STAT_EN defined, 257 completed frames -> frame_cnt=1; undefined -> frame_cnt=0 throughout.
